// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: machine word type and the occupancy state
// used by the registered skid stages.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid register: main register M drives the output, skid
// register S absorbs one extra word so in_ready never depends on out_ready.
module pipe_skid_reg
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state, state_n;
    logic [WIDTH-1:0] m_q, m_n;
    logic [WIDTH-1:0] s_q, s_n;
    logic             rdy_q;
    logic             vld_q;
    logic             accept;
    logic             pop;

    assign accept    = in_valid & rdy_q;
    assign pop       = vld_q & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = m_q;

    // Handshake flags are registered from the next state, keeping both
    // in_ready and out_valid free of any combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            state <= state_n;
            m_q   <= m_n;
            s_q   <= s_n;
            rdy_q <= (state_n != FULL);
            vld_q <= (state_n != EMPTY);
        end
    end

    always_comb begin
        state_n = state;
        m_n     = m_q;
        s_n     = s_q;
        if (flush) begin
            state_n = EMPTY;
            m_n     = '0;
            s_n     = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_n     = in_data;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_n = in_data;
                    end else if (accept) begin
                        s_n     = in_data;
                        state_n = FULL;
                    end else if (pop) begin
                        // Clear M on draining so stale data never shows.
                        m_n     = '0;
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_n     = s_q;
                        s_n     = '0;
                        state_n = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    m_n     = '0;
                    s_n     = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// N:1 binary-select mux feeding a registered skid stage; the out-of-range
// flag travels alongside the selected word.
module mux_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH      = XLEN,
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic [WIDTH:0]   skid_out;

    always_comb begin
        sel_word = '0;
        sel_err  = (32'(in_sel) >= NUM_INPUTS);
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    pipe_skid_reg #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({sel_err, sel_word}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (skid_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_err  = skid_out[WIDTH];
    assign out_data = skid_out[WIDTH-1:0];

endmodule
